// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish in one clock. MUL can optionally run as an
// iterative shift-add multiply over WIDTH clocks. Result and Z/N/C/V flags
// are held until the consumer takes them.
module alu_seq #(
  parameter int WIDTH  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               w_accept;
  logic               w_startMul;

  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;

  logic [2*WIDTH-1:0] r_accum;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SHW-1:0]     r_count;
  logic [2*WIDTH-1:0] w_accumNext;
  logic [WIDTH-1:0]   w_mulResult;
  logic [3:0]         w_mulFlags;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH-1:0]   w_opResult;
  logic [3:0]         w_opFlags;
  logic               w_c;
  logic               w_v;

  // The spare top bit catches the ADD carry, the SUB borrow and the last bit shifted out by SHL.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_shl  = {1'b0, a} << b[SHW-1:0];

  assign w_startMul = MUL_EN && (alu_sel == 3'b111);

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign w_accumNext = r_accum + (r_mplier[0] ? r_mcand : '0);
  assign w_mulResult = w_accumNext[WIDTH-1:0];
  assign w_mulFlags  = {w_mulResult == '0, w_mulResult[WIDTH-1],
                        |w_accumNext[2*WIDTH-1:WIDTH], 1'b0};

  // Single-cycle result and flags for the operation currently on the inputs.
  always_comb begin
    w_opResult = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    case (alu_sel)
      3'b000: begin
        w_opResult = w_sum[WIDTH-1:0];
        w_c        = w_sum[WIDTH];
        w_v        = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        w_opResult = w_diff[WIDTH-1:0];
        w_c        = w_diff[WIDTH];
        w_v        = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: w_opResult = a & b;
      3'b011: w_opResult = a | b;
      3'b100: w_opResult = ~a;
      3'b101: w_opResult = a ^ b;
      3'b110: begin
        w_opResult = w_shl[WIDTH-1:0];
        w_c        = w_shl[WIDTH];
      end
      default: w_opResult = '0;
    endcase
    w_opFlags = {w_opResult == '0, w_opResult[WIDTH-1], w_c, w_v};
  end

  // Handshake outputs and next state. In DONE, a new operation can be accepted in the same cycle the result is taken.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    w_accept = in_valid && in_ready;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)
          w_nextState = w_startMul ? BUSY : DONE;
        else if (r_state == DONE && out_ready)
          w_nextState = IDLE;
      end
      BUSY: if (r_count == LAST_STEP) w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Datapath: capture operands when a MUL is accepted, step the multiply while busy, and load the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_accum  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (r_state == BUSY) begin
      r_accum  <= w_accumNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == LAST_STEP) begin
        r_result <= w_mulResult;
        r_flags  <= w_mulFlags;
      end
    end else if (w_accept) begin
      if (w_startMul) begin
        r_accum  <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_count  <= '0;
      end else begin
        r_result <= w_opResult;
        r_flags  <= w_opFlags;
      end
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomised checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int vectorCount     = 0;
  int miscompareCount = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net in case the design stops responding entirely.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: evaluate the operation with plain integer arithmetic.
  function automatic void modelOp(input int op, input int av, input int bv, output int res, output int flg);
    int mask;
    int full;
    int sa, sb, sr;
    int c, v;
    mask = (1 << W) - 1;
    sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    c = 0;
    v = 0;
    res = 0;
    case (op)
      0: begin
        full = av + bv;  res = full & mask;  c = (full >> W) & 1;
        sr = sa + sb;    v = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
      end
      1: begin
        full = av - bv;  res = full & mask;  c = (av < bv) ? 1 : 0;
        sr = sa - sb;    v = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
      end
      2: res = av & bv;
      3: res = av | bv;
      4: res = (~av) & mask;
      5: res = av ^ bv;
      6: begin
        full = av << (bv % W);  res = full & mask;  c = (full >> W) & 1;
      end
      default: begin
        full = av * bv;  res = full & mask;  c = ((full >> W) != 0) ? 1 : 0;
      end
    endcase
    flg = ((res == 0) ? 8 : 0) + (((res >> (W - 1)) & 1) * 4) + c * 2 + v;
  endfunction

  // Present one operation from IDLE, wait (bounded) for the result, and check latency, result and flags.
  task automatic applyStimulus(input int op, input int av, input int bv, output int res, output int flg);
    int lat;
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    a        = W'(av);
    b        = W'(bv);
    alu_sel  = 3'(op);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    alu_sel  = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 3 * W) begin
      checkOutput("busy_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, (op == 7) ? W + 1 : 1);
    modelOp(op, av, bv, res, flg);
    checkOutput("result", 32'(result), res);
    checkOutput("flags", 32'(flags), flg);
  endtask

  // Keep out_ready low and confirm the result is held.
  task automatic holdCheck(input int cycles, input int res, input int flg);
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 1);
      checkOutput("hold_in_ready", 32'(in_ready), 0);
      checkOutput("hold_result", 32'(result), res);
      checkOutput("hold_flags", 32'(flags), flg);
    end
  endtask

  // Take the pending result and confirm the block is idle again.
  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("drained_out_valid", 32'(out_valid), 0);
    checkOutput("drained_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    int res, flg, res2, flg2;
    int op, stall;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_sel   = '0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_result", 32'(result), 0);
    checkOutput("rst_flags", 32'(flags), 0);
    rst_n = 1'b1;

    // ADD with wrap to zero, SUB borrow and signed overflow, MUL, SHL.
    applyStimulus(0, 15, 1, res, flg);
    checkOutput("add_F_1_flags", 32'(flags), 32'h0A);
    consume();
    applyStimulus(1, 3, 5, res, flg);
    checkOutput("sub_3_5_result", 32'(result), 32'hE);
    consume();
    applyStimulus(1, 8, 1, res, flg);
    checkOutput("sub_8_1_flags", 32'(flags), 32'h1);
    consume();
    applyStimulus(7, 7, 3, res, flg);
    checkOutput("mul_7_3_result", 32'(result), 32'h5);
    consume();
    applyStimulus(6, 6, 2, res, flg);
    checkOutput("shl_6_2_flags", 32'(flags), 32'h6);
    consume();

    // Back-to-back ADD then XOR with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'd5;  b = 4'd3;  alu_sel = 3'd0;
    @(posedge clk);
    @(negedge clk);
    modelOp(0, 5, 3, res, flg);
    checkOutput("b2b_add_valid", 32'(out_valid), 1);
    checkOutput("b2b_add_result", 32'(result), res);
    checkOutput("b2b_in_ready", 32'(in_ready), 1);
    a = 4'd12;  b = 4'd10;  alu_sel = 3'd5;
    @(posedge clk);
    @(negedge clk);
    modelOp(5, 12, 10, res, flg);
    in_valid = 1'b0;
    checkOutput("b2b_xor_valid", 32'(out_valid), 1);
    checkOutput("b2b_xor_result", 32'(result), res);
    checkOutput("b2b_xor_flags", 32'(flags), flg);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("b2b_drained", 32'(out_valid), 0);

    // Stall for five cycles, then take the result and accept a new op in the same cycle.
    applyStimulus(2, 12, 10, res, flg);
    holdCheck(5, res, flg);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'd9;  b = 4'd4;  alu_sel = 3'd3;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    modelOp(3, 9, 4, res2, flg2);
    checkOutput("same_cycle_valid", 32'(out_valid), 1);
    checkOutput("same_cycle_result", 32'(result), res2);
    checkOutput("same_cycle_flags", 32'(flags), flg2);
    consume();

    // Reset in the second busy cycle of a multiply.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd7;  b = 4'd3;  alu_sel = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midmul_rst_out_valid", 32'(out_valid), 0);
    checkOutput("midmul_rst_result", 32'(result), 0);
    checkOutput("midmul_rst_flags", 32'(flags), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 0);
    applyStimulus(7, 13, 11, res, flg);
    consume();

    // Randomised operations with random consumer stalls.
    repeat (60) begin
      op    = int'($urandom_range(0, 7));
      stall = int'($urandom_range(0, 2));
      applyStimulus(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), res, flg);
      holdCheck(stall, res, flg);
      consume();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
